// File: rtl/rv32_pkg.sv
// Shared RV32 definitions used by the EX stage.
//   - ALU_OP codes for the base ALU (ADD only, used to show non-M traffic) and the
//     RV32M multiply/divide group (MUL..REMU).
//   - mdu_state_t: state encoding of the multiply/divide unit.
//   - is_m_op(): true for any RV32M operation code.
package rv32_pkg;

  localparam int XLEN     = 32;
  localparam int OP_WIDTH = 5;

  localparam logic [OP_WIDTH-1:0] ALU_ADD    = 5'b00000;
  localparam logic [OP_WIDTH-1:0] ALU_MUL    = 5'b01000;
  localparam logic [OP_WIDTH-1:0] ALU_MULH   = 5'b01001;
  localparam logic [OP_WIDTH-1:0] ALU_MULHSU = 5'b01010;
  localparam logic [OP_WIDTH-1:0] ALU_MULHU  = 5'b01011;
  localparam logic [OP_WIDTH-1:0] ALU_DIV    = 5'b01100;
  localparam logic [OP_WIDTH-1:0] ALU_DIVU   = 5'b01101;
  localparam logic [OP_WIDTH-1:0] ALU_REM    = 5'b01110;
  localparam logic [OP_WIDTH-1:0] ALU_REMU   = 5'b01111;

  typedef enum logic [2:0] {
    MDU_IDLE     = 3'd0,
    MDU_MUL      = 3'd1,
    MDU_DIV_ITER = 3'd2,
    MDU_DIV_FIX  = 3'd3,
    MDU_DONE     = 3'd4
  } mdu_state_t;

  function automatic logic is_m_op(input logic [OP_WIDTH-1:0] op);
    return (op == ALU_MUL)  || (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_MULHU) ||
           (op == ALU_DIV)  || (op == ALU_DIVU) || (op == ALU_REM)    || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/mdu_divider_core.sv
// Iterative unsigned restoring divider, one quotient bit per enabled cycle.
// Ports:
//   CLK, RESET          clock, asynchronous active-high reset
//   load                capture dividend/divisor, clear the partial remainder
//   enable              perform one restoring step
//   dividend, divisor   unsigned operands (sampled on load)
//   quotient, remainder valid after XLEN enabled steps following a load
module mdu_divider_core #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            load,
  input  logic            enable,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] quo_reg;
  logic [XLEN-1:0] rem_reg;
  logic [XLEN-1:0] div_reg;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // The dividend shifts out of quo_reg MSB-first while quotient bits shift in at the LSB.
  assign shifted = {rem_reg, quo_reg[XLEN-1]};
  assign diff    = shifted - {1'b0, div_reg};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      quo_reg <= '0;
      rem_reg <= '0;
      div_reg <= '0;
    end else if (load) begin
      quo_reg <= dividend;
      rem_reg <= '0;
      div_reg <= divisor;
    end else if (enable) begin
      // A clear borrow bit means the trial subtraction fits: keep it, quotient bit 1.
      if (!diff[XLEN]) begin
        rem_reg <= diff[XLEN-1:0];
        quo_reg <= {quo_reg[XLEN-2:0], 1'b1};
      end else begin
        rem_reg <= shifted[XLEN-1:0];
        quo_reg <= {quo_reg[XLEN-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_reg;
  assign remainder = rem_reg;

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide unit sitting beside the ALU in EX.
// Ports:
//   CLK, RESET   clock, asynchronous active-high reset
//   START        ID/EX has just loaded a new valid instruction
//   FLUSH        abort any operation in progress
//   ALU_OP       operation code (MUL..REMU act, anything else is ignored)
//   OPERAND1/2   rs1 / rs2 after forwarding
//   RESULT       registered result, valid while DONE=1, held otherwise
//   DONE         one-cycle completion pulse
//   STALL        combinational pipeline hold request
//   BUSY         registered, high whenever the unit is not idle
// Multiplies finish two cycles after START, divides 34 cycles after START,
// divide-by-zero and signed overflow one cycle after START.
module ex_muldiv_unit
  import rv32_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int OP_WIDTH = 5
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                START,
  input  logic                FLUSH,
  input  logic [OP_WIDTH-1:0] ALU_OP,
  input  logic [XLEN-1:0]     OPERAND1,
  input  logic [XLEN-1:0]     OPERAND2,
  output logic [XLEN-1:0]     RESULT,
  output logic                DONE,
  output logic                STALL,
  output logic                BUSY
);

  localparam int CNT_W = $clog2(XLEN);

  mdu_state_t state_reg, state_next;

  logic [2*XLEN-1:0] product_reg;
  logic [OP_WIDTH-1:0] op_reg;
  logic              neg_q_reg;
  logic              neg_r_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [XLEN-1:0]   result_reg, result_next;
  logic              done_reg;
  logic              busy_reg;

  logic mul_load, div_load, div_step, result_load;

  // ---------------- operand decode ----------------
  logic is_m, is_mul_class, is_rem, signed_div, div_by_zero, overflow;
  assign is_m         = is_m_op(ALU_OP);
  assign is_mul_class = (ALU_OP == ALU_MUL) || (ALU_OP == ALU_MULH) ||
                        (ALU_OP == ALU_MULHSU) || (ALU_OP == ALU_MULHU);
  assign is_rem       = (ALU_OP == ALU_REM) || (ALU_OP == ALU_REMU);
  assign signed_div   = (ALU_OP == ALU_DIV) || (ALU_OP == ALU_REM);
  assign div_by_zero  = (OPERAND2 == '0);
  assign overflow     = signed_div && (OPERAND1 == {1'b1, {(XLEN-1){1'b0}}}) && (OPERAND2 == '1);

  logic [XLEN-1:0] special_result;
  always_comb begin
    special_result = '0;
    if (div_by_zero) special_result = is_rem ? OPERAND1 : '1;
    else             special_result = is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // ---------------- multiply ----------------
  // 33-bit operands carry the per-op signedness; widening them further by sign
  // extension keeps the low 64 bits of the product exact.
  logic               op1_signed, op2_signed;
  logic [XLEN:0]      mul_a, mul_b;
  logic signed [2*XLEN-1:0] mul_a_ext, mul_b_ext, prod_full;
  assign op1_signed = (ALU_OP != ALU_MULHU);
  assign op2_signed = (ALU_OP == ALU_MUL) || (ALU_OP == ALU_MULH);
  assign mul_a      = {op1_signed & OPERAND1[XLEN-1], OPERAND1};
  assign mul_b      = {op2_signed & OPERAND2[XLEN-1], OPERAND2};
  assign mul_a_ext  = {{(XLEN-1){mul_a[XLEN]}}, mul_a};
  assign mul_b_ext  = {{(XLEN-1){mul_b[XLEN]}}, mul_b};
  assign prod_full  = mul_a_ext * mul_b_ext;

  // ---------------- divide ----------------
  logic            op1_neg, op2_neg;
  logic [XLEN-1:0] abs1, abs2, quotient, remainder, q_signed, r_signed;
  assign op1_neg = signed_div & OPERAND1[XLEN-1];
  assign op2_neg = signed_div & OPERAND2[XLEN-1];
  assign abs1    = op1_neg ? -OPERAND1 : OPERAND1;
  assign abs2    = op2_neg ? -OPERAND2 : OPERAND2;

  mdu_divider_core #(.XLEN(XLEN)) u_div (
    .CLK       (CLK),
    .RESET     (RESET),
    .load      (div_load),
    .enable    (div_step),
    .dividend  (abs1),
    .divisor   (abs2),
    .quotient  (quotient),
    .remainder (remainder)
  );

  assign q_signed = neg_q_reg ? -quotient  : quotient;
  assign r_signed = neg_r_reg ? -remainder : remainder;

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_reg <= MDU_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    mul_load    = 1'b0;
    div_load    = 1'b0;
    div_step    = 1'b0;
    result_load = 1'b0;
    result_next = result_reg;
    unique case (state_reg)
      MDU_IDLE: begin
        if (START && is_m && !FLUSH) begin
          if (is_mul_class) begin
            mul_load   = 1'b1;
            state_next = MDU_MUL;
          end else if (div_by_zero || overflow) begin
            result_load = 1'b1;
            result_next = special_result;
            state_next  = MDU_DONE;
          end else begin
            div_load   = 1'b1;
            state_next = MDU_DIV_ITER;
          end
        end
      end
      MDU_MUL: begin
        result_load = 1'b1;
        result_next = (op_reg == ALU_MUL) ? product_reg[XLEN-1:0] : product_reg[2*XLEN-1:XLEN];
        state_next  = MDU_DONE;
      end
      MDU_DIV_ITER: begin
        div_step = 1'b1;
        if (count_reg == CNT_W'(XLEN-1)) state_next = MDU_DIV_FIX;
      end
      MDU_DIV_FIX: begin
        result_load = 1'b1;
        result_next = (op_reg == ALU_REM || op_reg == ALU_REMU) ? r_signed : q_signed;
        state_next  = MDU_DONE;
      end
      MDU_DONE: state_next = MDU_IDLE;
      default:  state_next = MDU_IDLE;
    endcase
    // A flush wins over every transition, including the write of a result.
    if (FLUSH && state_reg != MDU_IDLE) begin
      state_next  = MDU_IDLE;
      div_step    = 1'b0;
      result_load = 1'b0;
      result_next = result_reg;
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      product_reg <= '0;
      op_reg      <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      count_reg   <= '0;
      result_reg  <= '0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      if (mul_load) product_reg <= prod_full;
      if (mul_load || div_load) op_reg <= ALU_OP;
      if (div_load) begin
        neg_q_reg <= op1_neg ^ op2_neg;
        neg_r_reg <= op1_neg;
        count_reg <= '0;
      end else if (div_step) begin
        count_reg <= count_reg + CNT_W'(1);
      end
      if (result_load) result_reg <= result_next;
      done_reg <= (state_next == MDU_DONE);
      busy_reg <= (state_next != MDU_IDLE);
    end
  end

  assign RESULT = result_reg;
  assign DONE   = done_reg;
  assign BUSY   = busy_reg;
  assign STALL  = !RESET && ((state_reg == MDU_MUL) || (state_reg == MDU_DIV_ITER) ||
                             (state_reg == MDU_DIV_FIX) ||
                             ((state_reg == MDU_IDLE) && START && is_m));

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;
  import rv32_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic        FLUSH;
  logic [4:0]  ALU_OP;
  logic [31:0] OPERAND1;
  logic [31:0] OPERAND2;
  logic [31:0] RESULT;
  logic        DONE;
  logic        STALL;
  logic        BUSY;

  ex_muldiv_unit dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .START    (START),
    .FLUSH    (FLUSH),
    .ALU_OP   (ALU_OP),
    .OPERAND1 (OPERAND1),
    .OPERAND2 (OPERAND2),
    .RESULT   (RESULT),
    .DONE     (DONE),
    .STALL    (STALL),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  // Expected-behaviour model: one outstanding operation described by the cycle it
  // started, when STALL must drop, the last BUSY cycle and the DONE cycle.
  bit          checking = 0;
  bit          pend     = 0;
  int          t0, stall_end, busy_last, done_at;
  logic [31:0] pend_res;
  logic [31:0] hold = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub, p;
    logic [63:0] up;
    int          ia, ib, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      ALU_MUL:    begin p = sa * sb; return p[31:0];  end
      ALU_MULH:   begin p = sa * sb; return p[63:32]; end
      ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
      ALU_MULHU:  begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
      ALU_DIV: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        r = ia / ib; return r;
      end
      ALU_REM: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        r = ia % ib; return r;
      end
      ALU_DIVU: return (b == 0) ? 32'hFFFFFFFF : a / b;
      ALU_REMU: return (b == 0) ? a : a % b;
      default:  return 32'h0;
    endcase
  endfunction

  function automatic int latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU}) return 2;
    if (b == 0) return 1;
    if ((op == ALU_DIV || op == ALU_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 34;
  endfunction

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge CLK) begin
    if (checking && !RESET) begin
      logic e_done, e_stall, e_busy;
      e_done  = pend && (cyc == done_at);
      if (e_done) hold = pend_res;
      e_stall = pend && (cyc >= t0) && (cyc < stall_end);
      e_busy  = pend && (cyc > t0) && (cyc <= busy_last);
      chk("DONE",   32'(DONE),  32'(e_done));
      chk("STALL",  32'(STALL), 32'(e_stall));
      chk("BUSY",   32'(BUSY),  32'(e_busy));
      chk("RESULT", RESULT, hold);
    end
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge CLK); #1;
    START = 1'b1; ALU_OP = op; OPERAND1 = a; OPERAND2 = b;
    t0        = cyc;
    done_at   = cyc + latency(op, a, b);
    stall_end = done_at;
    busy_last = done_at;
    pend_res  = model(op, a, b);
    pend      = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    OPERAND1 = $urandom; OPERAND2 = $urandom;  // operands must have been captured
  endtask

  task automatic run(input string name, input logic [4:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] lit);
    int k;
    issue(op, a, b);
    k = 0;
    while (cyc <= busy_last && k < 60) begin
      @(posedge CLK); #1; k++;
    end
    if (cyc <= busy_last) chk({name, " timeout"}, 32'(cyc), 32'(busy_last + 1));
    chk({name, " value"}, RESULT, lit);
    pend = 1'b0;
    $display("%s op=%b a=%h b=%h result=%h latency=%0d", name, op, a, b, RESULT, done_at - t0);
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0; FLUSH = 1'b0;
    ALU_OP = ALU_ADD; OPERAND1 = 32'h0; OPERAND2 = 32'h0;
    #1;
    chk("reset RESULT", RESULT, 32'h0);
    chk("reset DONE",   32'(DONE),  32'h0);
    chk("reset BUSY",   32'(BUSY),  32'h0);
    chk("reset STALL",  32'(STALL), 32'h0);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    checking = 1'b1;

    // Multiplies
    run("MUL",    ALU_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB);
    run("MULH",   ALU_MULH,   32'h80000000, 32'h80000000, 32'h40000000);
    run("MULHU",  ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run("MULHSU", ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run("MUL2",   ALU_MUL,    32'h00012345, 32'h00001000, 32'h12345000);

    // Regular divides
    run("DIV",    ALU_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD);
    run("REM",    ALU_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF);
    run("DIVneg", ALU_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD);
    run("REMneg", ALU_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001);
    run("DIVU",   ALU_DIVU,   32'd100,      32'd7,        32'd14);
    run("REMU",   ALU_REMU,   32'd100,      32'd7,        32'd2);
    run("DIVUbig",ALU_DIVU,   32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF);

    // Special cases
    run("DIVU/0", ALU_DIVU,   32'h00000055, 32'h00000000, 32'hFFFFFFFF);
    run("REMU/0", ALU_REMU,   32'h00001234, 32'h00000000, 32'h00001234);
    run("DIVovf", ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run("REMovf", ALU_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000);

    // FLUSH during DIVU iteration 10
    issue(ALU_DIVU, 32'h0000FFFF, 32'h00000003);
    done_at = -1;
    repeat (10) begin @(posedge CLK); #1; end
    FLUSH = 1'b1;
    stall_end = cyc + 1;
    busy_last = cyc;
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end
    pend = 1'b0;
    $display("FLUSH-DIVU result held=%h", RESULT);
    run("MUL-after-flush", ALU_MUL, 32'h00000003, 32'h00000005, 32'h0000000F);

    // FLUSH together with START in IDLE: nothing starts
    @(posedge CLK); #1;
    START = 1'b1; FLUSH = 1'b1; ALU_OP = ALU_DIV; OPERAND1 = 32'd50; OPERAND2 = 32'd5;
    t0 = cyc; stall_end = cyc + 1; busy_last = cyc; done_at = -1; pend = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0; FLUSH = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end
    pend = 1'b0;
    $display("FLUSH+START no-start BUSY=%0d", BUSY);

    // RESET mid-divide, asserted between edges
    issue(ALU_DIV, 32'd1000, 32'd3);
    repeat (5) begin @(posedge CLK); #1; end
    @(negedge CLK); #2;
    RESET = 1'b1;
    #1;
    chk("midreset BUSY",   32'(BUSY),  32'h0);
    chk("midreset DONE",   32'(DONE),  32'h0);
    chk("midreset RESULT", RESULT,     32'h0);
    chk("midreset STALL",  32'(STALL), 32'h0);
    pend = 1'b0;
    hold = 32'h0;
    #1 RESET = 1'b0;
    $display("RESET mid-DIV BUSY=%0d RESULT=%h", BUSY, RESULT);

    // Non-M opcode with START is ignored
    @(posedge CLK); #1;
    START = 1'b1; ALU_OP = ALU_ADD; OPERAND1 = 32'd1; OPERAND2 = 32'd2;
    #1 chk("ADD STALL", 32'(STALL), 32'h0);
    @(posedge CLK); #1;
    START = 1'b0;
    #1 chk("ADD BUSY", 32'(BUSY), 32'h0);
    $display("ADD start ignored STALL=%0d BUSY=%0d", STALL, BUSY);

    run("DIV-after-reset", ALU_DIV, 32'd1000, 32'd3, 32'd333);

    repeat (2) @(posedge CLK);
    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
